// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl -- button / warmboot controller for iCE40 designs.
//
// A debounced button chooses between a user-logic reset (short press) and
// a warmboot into DFU_SLOT (long press). An external request can boot any
// slot. The chosen slot and BOOT bit feed an SB_WARMBOOT primitive. Once
// BOOT is set, the outputs hold until rst_n is asserted.
//
// Optional build macro WARMBOOT_CTRL_MULTICLICK_EN:
//   Short presses are collected into a click count.
//   GAP_TICKS of silence resolves the count:
//     1 click      -> reset pulse
//     2 or 3 clicks -> boot slot 2 or 3
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   btn_in   raw button pad (unsynchronised, polarity set by BTN_INV)
//   tick     single-cycle timebase strobe; all counters advance on it
//   ext_sel  slot for an external boot request
//   ext_req  external boot request (level sampled every cycle)
//   btn_val  filtered button level, 1 = pressed
//   armed    set once the button has been released for ARM_TICKS
//   rst_req  one-cycle user-logic reset request
//   wb_sel   slot driven to SB_WARMBOOT S1:S0
//   wb_boot  SB_WARMBOOT BOOT, sticky
module warmboot_ctrl #(
  parameter int CNT_W      = 12,
  parameter int FLT_TICKS  = 4,
  parameter int ARM_TICKS  = 500,
  parameter int LONG_TICKS = 2000,
  parameter int GAP_TICKS  = 400,
  parameter int BTN_INV    = 1,
  parameter int DFU_SLOT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       tick,
  input  logic [1:0] ext_sel,
  input  logic       ext_req,
  output logic       btn_val,
  output logic       armed,
  output logic       rst_req,
  output logic [1:0] wb_sel,
  output logic       wb_boot
);

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_PRESSED  = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_COMMIT   = 3'd4;
  localparam logic [2:0] S_BOOT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic             INV     = (BTN_INV != 0);
  localparam logic [CNT_W-1:0] FLT_M1  = CNT_W'(FLT_TICKS - 1);
  localparam logic [CNT_W-1:0] ARM_M1  = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
  localparam logic [1:0]       DFU_SEL = 2'(DFU_SLOT);

  // The synchroniser resets to the "released" pad level. This keeps the
  // filter from seeing a phantom press right after reset.
  logic             sync1_q, sync2_q;
  logic             btn_val_q, btn_val_d, btn_prev_q;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       state_q, state_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             wb_boot_q, wb_boot_d;
  logic             armed_q, armed_d;
  logic             rst_req_q, rst_req_d;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
  logic [1:0]       clicks_q, clicks_d;
`endif

  logic lvl, press_evt, rel_evt, ext_ok;

  assign lvl       = sync2_q ^ INV;
  assign press_evt = btn_val_q & ~btn_prev_q;
  assign rel_evt   = ~btn_val_q & btn_prev_q;
  assign ext_ok    = ext_req & ((state_q == S_DISARMED) | (state_q == S_ARMED) |
                                (state_q == S_PRESSED)  | (state_q == S_GAP));

  // Button filter: a new level must survive FLT_TICKS consecutive ticks.
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    btn_val_d = btn_val_q;
    if (lvl == btn_val_q) begin
      flt_cnt_d = '0;
    end else if (tick) begin
      if (flt_cnt_q == FLT_M1) begin
        btn_val_d = ~btn_val_q;
        flt_cnt_d = '0;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    target_d  = target_q;
    wb_sel_d  = wb_sel_q;
    wb_boot_d = wb_boot_q;
    armed_d   = armed_q;
    rst_req_d = 1'b0;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
    clicks_d  = clicks_q;
`endif
    if (ext_ok) begin
      // External request wins over any button event in the same cycle.
      target_d = ext_sel;
      state_d  = S_COMMIT;
      hold_d   = '0;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
      clicks_d = '0;
`endif
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (btn_val_q) begin
            hold_d = '0;
          end else if (tick) begin
            if (hold_q == ARM_M1) begin
              state_d = S_ARMED;
              armed_d = 1'b1;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (press_evt) begin
            state_d = S_PRESSED;
            hold_d  = '0;
          end
        end
        S_PRESSED: begin
          if (rel_evt) begin
            hold_d = '0;
            if (hold_q == LONG_C) begin
              target_d = DFU_SEL;
              state_d  = S_COMMIT;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
              clicks_d = '0;
`endif
            end else begin
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
              clicks_d = (clicks_q == 2'd3) ? 2'd3 : clicks_q + 2'd1;
              state_d  = S_GAP;
`else
              rst_req_d = 1'b1;
              state_d   = S_ARMED;
`endif
            end
          end else if (tick && (hold_q != LONG_C)) begin
            hold_d = hold_q + 1'b1;
          end
        end
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
        S_GAP: begin
          if (press_evt) begin
            state_d = S_PRESSED;
            hold_d  = '0;
          end else if (tick) begin
            if (hold_q == CNT_W'(GAP_TICKS - 1)) begin
              hold_d   = '0;
              clicks_d = '0;
              if (clicks_q == 2'd1) begin
                rst_req_d = 1'b1;
                state_d   = S_ARMED;
              end else begin
                target_d = clicks_q;
                state_d  = S_COMMIT;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
`endif
        // wb_sel settles one cycle before BOOT rises.
        S_COMMIT: begin
          wb_sel_d = target_q;
          state_d  = S_BOOT;
        end
        S_BOOT: begin
          wb_boot_d = 1'b1;
          state_d   = S_DONE;
        end
        S_DONE: begin
        end
        default: state_d = S_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= INV;
      sync2_q    <= INV;
      btn_val_q  <= 1'b0;
      btn_prev_q <= 1'b0;
      flt_cnt_q  <= '0;
      hold_q     <= '0;
      state_q    <= S_DISARMED;
      target_q   <= 2'd0;
      wb_sel_q   <= 2'd0;
      wb_boot_q  <= 1'b0;
      armed_q    <= 1'b0;
      rst_req_q  <= 1'b0;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
      clicks_q   <= 2'd0;
`endif
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      btn_val_q  <= btn_val_d;
      btn_prev_q <= btn_val_q;
      flt_cnt_q  <= flt_cnt_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      target_q   <= target_d;
      wb_sel_q   <= wb_sel_d;
      wb_boot_q  <= wb_boot_d;
      armed_q    <= armed_d;
      rst_req_q  <= rst_req_d;
`ifdef WARMBOOT_CTRL_MULTICLICK_EN
      clicks_q   <= clicks_d;
`endif
    end
  end

  assign btn_val = btn_val_q;
  assign armed   = armed_q;
  assign rst_req = rst_req_q;
  assign wb_sel  = wb_sel_q;
  assign wb_boot = wb_boot_q;

endmodule

// File: doc/warmboot_ctrl.md
Name: warmboot_ctrl

Overview:
- Next-generation button/warmboot controller for iCE40 designs. Replaces the fixed short/long-press scheme with parametrised timing and a tick-based button filter.
- Press duration selects between logic reset and DFU boot; optional multi-click selects further image slots.
- External boot request path included. Drives an internal SB_WARMBOOT primitive.
- Sits at top level next to the USB/DFU core; one instance per design.

Parameters:
- CNT_W, 12, width of tick counters; all *_TICKS values must be < 2^CNT_W.
- FLT_TICKS, 4, consecutive ticks a new button level must persist to be accepted.
- ARM_TICKS, 500, ticks of continuous release after reset before presses are honoured.
- LONG_TICKS, 2000, hold ticks at or above which a press is "long".
- GAP_TICKS, 400, inter-click window (multi-click build only).
- BTN_INV, 1, 1 = btn_in active-low.
- DFU_SLOT, 1, image slot (0..3) booted by a long press.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- btn_in  in  1  raw button pad level (unsynchronised)
- tick  in  1  single-cycle timebase strobe (e.g. 1 kHz)
- ext_sel  in  2  image slot for external request
- ext_req  in  1  external boot request, sampled when high
- btn_val  out  1  filtered button level, 1 = pressed
- armed  out  1  high once the arming condition is met
- rst_req  out  1  one-cycle pulse requesting user-logic reset
- wb_sel  out  2  registered slot currently driven to SB_WARMBOOT S1:S0
- wb_boot  out  1  SB_WARMBOOT BOOT input; sticky once set

Behaviour:
- Reset values: btn_val=0, armed=0, rst_req=0, wb_sel=0, wb_boot=0, state=DISARMED, all counters=0.
- Input path: 2-FF synchroniser, then XOR with BTN_INV.
  - Filter counter counts on tick while the synchronised level differs from btn_val, and clears when it equals btn_val.
  - On reaching FLT_TICKS, btn_val toggles and the counter clears.
  - Press event = btn_val rising; release event = btn_val falling (one cycle each).
- States: DISARMED, ARMED, PRESSED, GAP, COMMIT, BOOT, DONE.
- DISARMED:
  - Hold counter counts ticks while btn_val=0 and clears on btn_val=1.
  - At ARM_TICKS, go to ARMED and set armed=1; armed stays 1 until reset.
  - Presses held since power-up are therefore ignored.
- ARMED:
  - Press event: go to PRESSED and clear the hold counter.
- PRESSED:
  - Hold counter increments on tick, saturating at LONG_TICKS.
  - Release with counter == LONG_TICKS: latch DFU_SLOT as target, go to COMMIT.
  - Release with counter < LONG_TICKS, base build: rst_req pulses for the release cycle +1, return to ARMED.
  - Holding past LONG_TICKS does not boot until release.
- COMMIT: wb_sel <= target; next state BOOT.
- BOOT: wb_boot <= 1; next state DONE.
- DONE: terminal. wb_boot and wb_sel are held until rst_n asserts; all further inputs are ignored.
- External request:
  - ext_req=1 in DISARMED, ARMED, PRESSED or GAP: target <= ext_sel, go to COMMIT.
  - Takes priority over any same-cycle button event, and suppresses that cycle's rst_req.
  - ext_req in COMMIT, BOOT or DONE is ignored.
- Latency: ext_req high at cycle N gives wb_sel valid at N+1 and wb_boot high at N+2. A qualifying release follows the same timing from the release-event cycle.
- wb_sel never changes in the same cycle wb_boot rises.
- Reset mid-operation: rst_n low returns everything to reset values immediately (async). The design re-arms only after ARM_TICKS of release.
- tick held high continuously is legal; counters then run at clk rate.

Optional Feature:
- Macro: WARMBOOT_CTRL_MULTICLICK_EN.
- Defined:
  - A short release increments the click count (2-bit, saturating at 3), clears the hold counter, and goes to GAP.
  - GAP counts ticks.
    - Press in GAP: go to PRESSED, keeping the click count.
    - Counter reaches GAP_TICKS: resolve the click count.
      - count=1: rst_req pulse, return to ARMED.
      - count=2 or 3: target = count, go to COMMIT.
    - The click count clears on leaving GAP.
  - A long release always boots DFU_SLOT, regardless of the click count.
- Undefined: GAP is unreachable, no click counter is built, and GAP_TICKS is unused.

Test Plan:
- Pulse btn low for 3 ticks (FLT_TICKS=4) after arming -> btn_val stays 0, no rst_req, state ARMED.
- Button held low from reset for 3000 ticks, then released -> armed rises exactly ARM_TICKS ticks after release; wb_boot never asserts.
- Armed, press for 100 ticks, release -> single-cycle rst_req; wb_boot=0; state ARMED.
- Armed, press for 2500 ticks, release -> wb_sel=1 one cycle after COMMIT, wb_boot=1 the next cycle; both hold for 10000 cycles.
- ext_sel=3, ext_req pulsed at cycle N in the same cycle as a short release -> wb_sel=3 at N+1, wb_boot at N+2, no rst_req; a second ext_req with ext_sel=0 leaves wb_sel=3.
- MULTICLICK_EN: three 50-tick clicks 100 ticks apart -> GAP_TICKS after the last release, wb_sel=3 then wb_boot=1. Then assert rst_n low mid-GAP in a second run -> all outputs 0, armed=0.
